// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: operation codes and controller states.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        F_ADD   = 4'd0,
        F_SUB   = 4'd1,
        F_AND   = 4'd2,
        F_OR    = 4'd3,
        F_XOR   = 4'd4,
        F_NOT   = 4'd5,
        F_ROL   = 4'd6,
        F_ROR   = 4'd7,
        F_SHL   = 4'd8,
        F_SHR   = 4'd9,
        F_MUL   = 4'd10,
        F_ADC   = 4'd11,
        F_SBB   = 4'd12,
        F_CMP   = 4'd13,
        F_RSV14 = 4'd14,
        F_RSV15 = 4'd15
    } func_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic is_shift(input func_e f);
        return f inside {F_ROL, F_ROR, F_SHL, F_SHR};
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU: arithmetic, logic ops and their flags.
module alu_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  func_e              func,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cin,
    output logic [WIDTH-1:0]   res,
    output logic               wr_res,
    output logic               carry,
    output logic               ovf,
    output logic               zero,
    output logic               neg,
    output logic               valid
);

    localparam int M = WIDTH - 1;

    logic [WIDTH:0] ext;
    logic [WIDTH:0] cin_ext;

    assign cin_ext = {{WIDTH{1'b0}}, cin};

    always_comb begin
        ext    = '0;
        res    = '0;
        wr_res = 1'b1;
        carry  = 1'b0;
        ovf    = 1'b0;
        valid  = 1'b1;
        case (func)
            F_ADD, F_ADC: begin
                ext   = {1'b0, a} + {1'b0, b} + ((func == F_ADC) ? cin_ext : '0);
                res   = ext[M:0];
                carry = ext[WIDTH];
                ovf   = (a[M] == b[M]) && (res[M] != a[M]);
            end
            F_SUB, F_SBB, F_CMP: begin
                // top bit of the extended difference is the unsigned borrow
                ext    = {1'b0, a} - {1'b0, b} - ((func == F_SBB) ? cin_ext : '0);
                res    = ext[M:0];
                carry  = ext[WIDTH];
                ovf    = (a[M] != b[M]) && (res[M] != a[M]);
                wr_res = (func != F_CMP);
            end
            F_AND: res = a & b;
            F_OR:  res = a | b;
            F_XOR: res = a ^ b;
            F_NOT: res = ~a;
            default: begin
                valid  = 1'b0;
                wr_res = 1'b0;
            end
        endcase
    end

    assign zero = (res == '0);
    assign neg  = res[M];

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops via alu_core, bit-serial shifts/rotates and shift-add multiply.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        func,
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic              carry_f,
    output logic              zero_f,
    output logic              neg_f,
    output logic              ovf_f
);

    localparam int M  = WIDTH - 1;
    localparam int CW = SHW + 1;

    state_e           state, state_nxt;
    func_e            func_in, func_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [WIDTH-1:0] acc_hi, hi_nxt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   mul_sum;
    logic             step_c;
    logic [SHW-1:0]   k;
    logic             accept, multi, finish;

    logic [WIDTH-1:0] c_res;
    logic             c_wr, c_carry, c_ovf, c_zero, c_neg, c_valid;

    assign func_in = func_e'(func);
    assign k       = op_b[SHW-1:0];

    alu_core #(.WIDTH(WIDTH)) u_core (
        .func   (func_in),
        .a      (op_a),
        .b      (op_b),
        .cin    (carry_f),
        .res    (c_res),
        .wr_res (c_wr),
        .carry  (c_carry),
        .ovf    (c_ovf),
        .zero   (c_zero),
        .neg    (c_neg),
        .valid  (c_valid)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        multi     = (is_shift(func_in) && (k != '0)) || (func_in == F_MUL);
        finish    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                accept    = start;
                state_nxt = start ? (multi ? S_RUN : S_DONE) : S_IDLE;
            end
            S_RUN: begin
                finish    = (cnt == CW'(1));
                state_nxt = finish ? S_DONE : S_RUN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // one bit of the running shift/rotate or one multiply partial product
    always_comb begin
        sr_nxt  = sr;
        hi_nxt  = acc_hi;
        step_c  = 1'b0;
        mul_sum = '0;
        case (func_q)
            F_ROL: begin step_c = sr[M]; sr_nxt = {sr[M-1:0], sr[M]};  end
            F_ROR: begin step_c = sr[0]; sr_nxt = {sr[0], sr[M:1]};    end
            F_SHL: begin step_c = sr[M]; sr_nxt = {sr[M-1:0], 1'b0};   end
            F_SHR: begin step_c = sr[0]; sr_nxt = {1'b0, sr[M:1]};     end
            F_MUL: begin
                mul_sum = {1'b0, acc_hi} + (sr[0] ? {1'b0, mcand} : '0);
                hi_nxt  = mul_sum[WIDTH:1];
                sr_nxt  = {mul_sum[0], sr[M:1]};
                step_c  = (hi_nxt != '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            func_q  <= F_ADD;
            cnt     <= '0;
            sr      <= '0;
            acc_hi  <= '0;
            mcand   <= '0;
            result  <= '0;
            carry_f <= 1'b0;
            zero_f  <= 1'b0;
            neg_f   <= 1'b0;
            ovf_f   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                func_q <= func_in;
                sr     <= op_a;
                acc_hi <= '0;
                mcand  <= op_b;
                cnt    <= (func_in == F_MUL) ? CW'(WIDTH) : {1'b0, k};
                if (!multi) begin
                    if (is_shift(func_in)) begin
                        result  <= op_a;
                        carry_f <= 1'b0;
                        zero_f  <= (op_a == '0);
                        neg_f   <= op_a[M];
                        ovf_f   <= 1'b0;
                    end else if (c_valid) begin
                        if (c_wr) result <= c_res;
                        carry_f <= c_carry;
                        zero_f  <= c_zero;
                        neg_f   <= c_neg;
                        ovf_f   <= c_ovf;
                    end
                end
            end else if (state == S_RUN) begin
                cnt    <= cnt - CW'(1);
                sr     <= sr_nxt;
                acc_hi <= hi_nxt;
                if (finish) begin
                    result  <= sr_nxt;
                    carry_f <= step_c;
                    zero_f  <= (sr_nxt == '0);
                    neg_f   <= sr_nxt[M];
                    ovf_f   <= 1'b0;
                end
            end
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8 with hand-computed expectations.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] func = 4'd0;
    logic [7:0] op_a = 8'd0;
    logic [7:0] op_b = 8'd0;
    logic       busy, done;
    logic [7:0] result;
    logic       carry_f, zero_f, neg_f, ovf_f;

    int errors = 0;
    int checks = 0;
    int lat, bcnt, dcnt;

    alu_seq #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .func    (func),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .carry_f (carry_f),
        .zero_f  (zero_f),
        .neg_f   (neg_f),
        .ovf_f   (ovf_f)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // flags packed as {carry, zero, neg, ovf}
    function automatic logic [3:0] flags();
        return {carry_f, zero_f, neg_f, ovf_f};
    endfunction

    // issue one op, scramble inputs afterwards, return latency to done and busy cycles
    task automatic run_op(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                          output int l, output int bc);
        @(negedge clk);
        start = 1'b1; func = f; op_a = a; op_b = b;
        l = 0; bc = 0;
        forever begin
            @(negedge clk);
            start = 1'b0;
            func  = 4'($urandom_range(0, 15));
            op_a  = 8'($urandom);
            op_b  = 8'($urandom);
            l++;
            if (busy) bc++;
            if (done) break;
            if (l > 40) begin
                check("timeout_done", 32'(done), 32'd1);
                break;
            end
        end
    endtask

    task automatic expect_op(input string tag, input logic [3:0] f, input logic [7:0] a,
                             input logic [7:0] b, input int el, input int eb,
                             input logic [7:0] er, input logic [3:0] ef);
        int l, bc;
        run_op(f, a, b, l, bc);
        check({tag, "_lat"},  32'(l), 32'(el));
        check({tag, "_busy"}, 32'(bc), 32'(eb));
        check({tag, "_res"},  32'(result), 32'(er));
        check({tag, "_flags"}, 32'(flags()), 32'(ef));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy",   32'(busy), 0);
        check("rst_done",   32'(done), 0);
        check("rst_result", 32'(result), 0);
        check("rst_flags",  32'(flags()), 0);
        reset = 1'b0;

        expect_op("add_ff_01", 4'd0, 8'hFF, 8'h01, 1, 0, 8'h00, 4'b1100);
        @(negedge clk);
        check("add_done_pulse", 32'(done), 0);
        expect_op("sub_80_01", 4'd1, 8'h80, 8'h01, 1, 0, 8'h7F, 4'b0001);
        expect_op("sbb_05_05", 4'd12, 8'h05, 8'h05, 1, 0, 8'h00, 4'b0100);
        expect_op("rol_81_3", 4'd6, 8'h81, 8'h03, 4, 3, 8'h0C, 4'b0000);
        expect_op("rol_81_0", 4'd6, 8'h81, 8'h00, 1, 0, 8'h81, 4'b0010);
        expect_op("ror_01_2", 4'd7, 8'h01, 8'h02, 3, 2, 8'h40, 4'b0000);
        expect_op("shr_81_1", 4'd9, 8'h81, 8'h01, 2, 1, 8'h40, 4'b1000);
        expect_op("shl_c1_7", 4'd8, 8'hC1, 8'h07, 8, 7, 8'h80, 4'b0010);
        expect_op("xor_f0_ff", 4'd4, 8'hF0, 8'hFF, 1, 0, 8'h0F, 4'b0000);
        expect_op("mul_10_11", 4'd10, 8'h10, 8'h11, 9, 8, 8'h10, 4'b1000);

        // MUL with a second start at cycle 3 that must be dropped
        @(negedge clk);
        start = 1'b1; func = 4'd10; op_a = 8'h0F; op_b = 8'h0F;
        lat = 0; dcnt = 0; bcnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (lat == 2) begin start = 1'b1; func = 4'd0; op_a = 8'h01; op_b = 8'h01; end
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                check("mul_ign_lat", 32'(lat), 9);
                check("mul_ign_res", 32'(result), 32'h E1);
                check("mul_ign_flags", 32'(flags()), 32'b0010);
            end
        end
        check("mul_ign_dones", 32'(dcnt), 1);
        check("mul_ign_busy", 32'(bcnt), 8);

        // reset at cycle 4 of a MUL
        @(negedge clk);
        start = 1'b1; func = 4'd10; op_a = 8'h03; op_b = 8'h05;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy",   32'(busy), 0);
        check("abort_done",   32'(done), 0);
        check("abort_result", 32'(result), 0);
        check("abort_flags",  32'(flags()), 0);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("abort_no_done", 32'(dcnt), 0);
        expect_op("add_2_3", 4'd0, 8'h02, 8'h03, 1, 0, 8'h05, 4'b0000);

        expect_op("cmp_03_05", 4'd13, 8'h03, 8'h05, 1, 0, 8'h05, 4'b1010);
        expect_op("rsv_14", 4'd14, 8'hAA, 8'h55, 1, 0, 8'h05, 4'b1010);
        expect_op("adc_01_01", 4'd11, 8'h01, 8'h01, 1, 0, 8'h03, 4'b0000);
        expect_op("add_7f_01", 4'd0, 8'h7F, 8'h01, 1, 0, 8'h80, 4'b0011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width; power of two, minimum 4.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width (derived, not overridden).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; accepted on a rising edge where start=1 and busy=0.
REQ-006 SHALL have port func  input  4  operation code, sampled at acceptance.
REQ-007 SHALL have ports op_a, op_b  input  WIDTH  operands, sampled at acceptance.
REQ-008 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse: result/flags just updated.
REQ-010 SHALL have port result  output  WIDTH  registered result, held until next done.
REQ-011 SHALL have ports carry_f, zero_f, neg_f, ovf_f  output  1 each  registered flags, held until next done.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; busy=1 only in RUN; done=1 only in DONE; DONE lasts one cycle then IDLE unless a new start is accepted.
REQ-013 SHALL accept start in IDLE or DONE (back-to-back allowed); start while busy=1 SHALL be ignored, not queued.
REQ-014 SHALL decode func: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT op_a, 6 ROL, 7 ROR, 8 SHL, 9 SHR (logical), 10 MUL, 11 ADC (op_a+op_b+carry_f), 12 SBB (op_a-op_b-carry_f), 13 CMP, 14-15 reserved.
REQ-015 Single-cycle ops (0-5, 11-15): accepting edge goes to DONE; done high in the next cycle (latency 1).
REQ-016 Shifts/rotates: amount k = op_b[SHW-1:0]; k=0 behaves as single-cycle (result=op_a, carry_f=0); k>0 enters RUN, one bit per edge, k edges in RUN, latency k+1, busy high k cycles.
REQ-017 MUL: shift-add, WIDTH edges in RUN, latency WIDTH+1; result = low WIDTH bits of unsigned product; carry_f=1 iff high WIDTH bits nonzero; ovf_f=0.
REQ-018 ADD/ADC: carry_f = carry out of bit WIDTH-1; ovf_f = signed overflow.
REQ-019 SUB/SBB/CMP: carry_f = unsigned borrow; ovf_f = signed overflow; CMP updates flags only, result unchanged.
REQ-020 Logic ops: carry_f=0, ovf_f=0.
REQ-021 Shifts/rotates: carry_f = last bit moved out; ovf_f=0.
REQ-022 All ops except reserved: zero_f = (new result value == 0) (for CMP, of the difference); neg_f = its MSB.
REQ-023 Reserved codes: done pulses at latency 1, result and all flags unchanged.
REQ-024 Operands SHALL be internally latched; op_a/op_b/func changes after acceptance SHALL not affect the running operation.

Reset
REQ-025 reset=1 at a rising edge SHALL force IDLE, busy=0, done=0, result=0, all flags=0, irrespective of state (incl. mid-RUN) and of start.
REQ-026 Aborted operations SHALL produce no done pulse and no result/flag update.

Structure
REQ-027 Package alu_seq_pkg SHALL hold the func enum (14 named codes plus reserved) and the state enum.
REQ-028 Single-cycle compute (ops 0-5, 11-13, flags) SHALL be a combinational sub-module alu_core, parameterised by WIDTH; the FSM, step counter and shift/multiply registers stay in alu_seq.

Verification (WIDTH=8)
REQ-029 ADD 8'hFF+8'h01 -> done at latency 1, result 8'h00, carry 1, zero 1, neg 0, ovf 0.
REQ-030 SUB 8'h80-8'h01 -> result 8'h7F, carry 0, ovf 1, neg 0, zero 0; then SBB 8'h05-8'h05 with carry_f=0 -> 8'h00, zero 1.
REQ-031 ROL op_a=8'h81 op_b=3 -> busy 3 cycles, done at latency 4, result 8'h0C, carry 0; ROL op_b=0 -> latency 1, result 8'h81.
REQ-032 MUL 8'h10*8'h11 -> busy 8 cycles, done at latency 9, result 8'h10, carry 1, zero 0.
REQ-033 MUL in progress, start with ADD at cycle 3 -> ignored; single done at latency 9 with MUL result only.
REQ-034 reset at cycle 4 of MUL -> next cycle busy 0, done 0, result 0, flags 0, no later done; then ADD 2+3 -> result 8'h05 at latency 1.
